// File: rtl/adsr_pkg.sv
// rtl/adsr_pkg.sv - shared ADSR amplitude width, phase encoding and helpers
package adsr_pkg;

    localparam int AMP_W = 8;

    // Phase encoding shared with the envelope generator
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } phase_e;

    function automatic logic [AMP_W-1:0] amp_max(input logic [AMP_W-1:0] a,
                                                 input logic [AMP_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/adsr_envelope_analyzer_if.sv
// rtl/adsr_envelope_analyzer_if.sv - amplitude sample stream into the ADSR analyzer
interface adsr_envelope_analyzer_if;
    import adsr_pkg::*;

    logic             sample_valid;
    logic [AMP_W-1:0] amplitude;

    modport master (output sample_valid, output amplitude);
    modport slave  (input  sample_valid, input  amplitude);

endinterface

// File: rtl/adsr_sat_counter.sv
// rtl/adsr_sat_counter.sv - phase-length counter with clear, load-1 and saturating increment
module adsr_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_load1,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    // Clear wins over load-1, load-1 wins over increment; increment sticks at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_load1) begin
            r_count <= CNT_W'(1);
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/adsr_envelope_analyzer.sv
// rtl/adsr_envelope_analyzer.sv - recovers ADSR shape from an amplitude stream (optional ADSR_ANALYZER_TIMEOUT_EN)
module adsr_envelope_analyzer
    import adsr_pkg::*;
#(
    parameter int CNT_W          = 16,
    parameter int STABLE_SAMPLES = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    adsr_envelope_analyzer_if.slave  s_if,
    output logic [2:0]               o_phase,
    output logic                     o_result_valid,
    output logic [AMP_W-1:0]         o_peak_level,
    output logic [AMP_W-1:0]         o_sustain_level,
    output logic [CNT_W-1:0]         o_attack_cycles,
    output logic [CNT_W-1:0]         o_decay_cycles,
    output logic [CNT_W-1:0]         o_sustain_cycles,
    output logic [CNT_W-1:0]         o_release_cycles,
    output logic                     o_no_sustain,
    output logic                     o_retrig_err,
    output logic                     o_timeout_err
);

    localparam int C_ATT = 0;
    localparam int C_DEC = 1;
    localparam int C_SUS = 2;
    localparam int C_REL = 3;
    localparam logic [7:0] STABLE_LIM = 8'(STABLE_SAMPLES);

    phase_e           r_phase, w_phase_next;
    logic [AMP_W-1:0] r_prev, r_peak, w_peak_next, r_sus_lvl, w_sus_lvl_next;
    logic [7:0]       r_stable, w_stable_next, w_stable_inc;
    logic             r_retrig, w_retrig_next, r_sus_seen, w_sus_seen_next;
    logic             w_accept, w_complete, w_start, w_retrigger, w_timeout;
    logic [AMP_W-1:0] w_amp;
    logic [3:0]       w_clr, w_ld, w_inc;
    logic [CNT_W-1:0] w_cnt [4];

    assign w_accept     = s_if.sample_valid;
    assign w_amp        = s_if.amplitude;
    assign w_stable_inc = r_stable + 8'd1;
    assign o_phase      = r_phase;

    for (genvar g = 0; g < 4; g++) begin : g_cnt
        adsr_sat_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_clear (w_clr[g]),
            .i_load1 (w_ld[g]),
            .i_inc   (w_inc[g]),
            .o_count (w_cnt[g])
        );
    end

`ifdef ADSR_ANALYZER_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [IDLE_W-1:0] r_idle, w_idle_next;
    assign w_idle_next = r_idle + IDLE_W'(1);

    // Count clocks without a sample while an envelope is open
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idle <= '0;
        end else if (w_accept || (r_phase == IDLE) || w_complete) begin
            r_idle <= '0;
        end else begin
            r_idle <= w_idle_next;
        end
    end
`else
    // Timeout logic not built; this expression is constant 0
    assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

    // Next phase and per-counter controls for the sample accepted this cycle
    always_comb begin
        w_phase_next    = r_phase;
        w_peak_next     = r_peak;
        w_sus_lvl_next  = r_sus_lvl;
        w_stable_next   = r_stable;
        w_retrig_next   = r_retrig;
        w_sus_seen_next = r_sus_seen;
        w_clr           = '0;
        w_ld            = '0;
        w_inc           = '0;
        w_complete      = 1'b0;
        w_start         = 1'b0;
        w_retrigger     = 1'b0;
`ifdef ADSR_ANALYZER_TIMEOUT_EN
        w_timeout       = 1'b0;
`endif
        if (w_accept) begin
            if ((r_phase != IDLE) && (w_amp == '0)) begin
                w_complete = 1'b1;
            end else begin
                case (r_phase)
                    IDLE: begin
                        if (w_amp != '0) w_start = 1'b1;
                    end
                    ATTACK: begin
                        if (w_amp >= r_prev) begin
                            w_inc[C_ATT] = 1'b1;
                            w_peak_next  = amp_max(r_peak, w_amp);
                        end else begin
                            w_phase_next  = DECAY;
                            w_ld[C_DEC]   = 1'b1;
                            w_stable_next = '0;
                        end
                    end
                    DECAY: begin
                        if (w_amp < r_prev) begin
                            w_inc[C_DEC]  = 1'b1;
                            w_stable_next = '0;
                        end else if (w_amp == r_prev) begin
                            w_inc[C_DEC]  = 1'b1;
                            w_stable_next = w_stable_inc;
                            if (w_stable_inc == STABLE_LIM) begin
                                w_phase_next    = SUSTAIN;
                                w_sus_lvl_next  = w_amp;
                                w_sus_seen_next = 1'b1;
                            end
                        end else begin
                            w_retrigger = 1'b1;
                        end
                    end
                    SUSTAIN: begin
                        if (w_amp == r_prev) begin
                            w_inc[C_SUS] = 1'b1;
                        end else if (w_amp < r_prev) begin
                            w_phase_next = RELEASE;
                            w_ld[C_REL]  = 1'b1;
                        end else begin
                            w_retrigger = 1'b1;
                        end
                    end
                    RELEASE: begin
                        if (w_amp <= r_prev) w_inc[C_REL] = 1'b1;
                        else                 w_retrigger  = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
`ifdef ADSR_ANALYZER_TIMEOUT_EN
        else if ((r_phase != IDLE) && (w_idle_next == IDLE_W'(TIMEOUT_CYCLES))) begin
            w_complete = 1'b1;
            w_timeout  = 1'b1;
        end
`endif
        // A fresh start and a retrigger both restart the shape at ATTACK
        if (w_start || w_retrigger) begin
            w_phase_next    = ATTACK;
            w_clr           = 4'b1110;
            w_ld[C_ATT]     = 1'b1;
            w_peak_next     = w_amp;
            w_sus_lvl_next  = '0;
            w_stable_next   = '0;
            w_sus_seen_next = 1'b0;
            w_retrig_next   = w_retrigger;
        end
        if (w_complete) begin
            w_phase_next  = IDLE;
            w_clr         = 4'b1111;
            w_stable_next = '0;
        end
    end

    // Working state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase    <= IDLE;
            r_prev     <= '0;
            r_peak     <= '0;
            r_sus_lvl  <= '0;
            r_stable   <= '0;
            r_retrig   <= 1'b0;
            r_sus_seen <= 1'b0;
        end else begin
            r_phase    <= w_phase_next;
            r_peak     <= w_peak_next;
            r_sus_lvl  <= w_sus_lvl_next;
            r_stable   <= w_stable_next;
            r_retrig   <= w_retrig_next;
            r_sus_seen <= w_sus_seen_next;
            if (w_accept) r_prev <= w_amp;
        end
    end

    // Result record: loaded once per completed envelope, held until the next one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_result_valid   <= 1'b0;
            o_peak_level     <= '0;
            o_sustain_level  <= '0;
            o_attack_cycles  <= '0;
            o_decay_cycles   <= '0;
            o_sustain_cycles <= '0;
            o_release_cycles <= '0;
            o_no_sustain     <= 1'b0;
            o_retrig_err     <= 1'b0;
            o_timeout_err    <= 1'b0;
        end else begin
            o_result_valid <= w_complete;
            if (w_complete) begin
                o_peak_level     <= r_peak;
                o_sustain_level  <= r_sus_lvl;
                o_attack_cycles  <= w_cnt[C_ATT];
                o_decay_cycles   <= w_cnt[C_DEC];
                o_sustain_cycles <= w_cnt[C_SUS];
                o_release_cycles <= w_cnt[C_REL];
                o_no_sustain     <= ~r_sus_seen;
                o_retrig_err     <= r_retrig;
                o_timeout_err    <= w_timeout;
            end
        end
    end

endmodule
